// File: rtl/vending_txn_controller.sv
// Vending machine transaction sequencer: coin intake, credit tracking,
// item arbitration against credit, inactivity timeout and change payout.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | no credit; waiting for the first coin
// S_CREDIT | credit held; serving selections, timing inactivity
// S_RETURN | paying change back one coin per cycle (o_busy high)
module vending_txn_controller #(
    parameter int TOTAL_BITS  = 31,
    parameter int WAIT_CYCLES = 100,
    parameter int COIN0       = 100,
    parameter int COIN1       = 500,
    parameter int COIN2       = 1000,
    parameter int PRICE0      = 400,
    parameter int PRICE1      = 500,
    parameter int PRICE2      = 1000,
    parameter int PRICE3      = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            i_input_coin,
    input  logic [3:0]            i_select_item,
    input  logic                  i_trigger_return,
    output logic [3:0]            o_available_item,
    output logic [3:0]            o_output_item,
    output logic [2:0]            o_return_coin,
    output logic                  o_coin_reject,
    output logic [TOTAL_BITS-1:0] current_total,
    output logic [TOTAL_BITS-1:0] wait_time,
    output logic                  o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_RETURN = 2'd2;

    localparam logic [TOTAL_BITS-1:0] C0   = TOTAL_BITS'(COIN0);
    localparam logic [TOTAL_BITS-1:0] C1   = TOTAL_BITS'(COIN1);
    localparam logic [TOTAL_BITS-1:0] C2   = TOTAL_BITS'(COIN2);
    localparam logic [TOTAL_BITS-1:0] P0   = TOTAL_BITS'(PRICE0);
    localparam logic [TOTAL_BITS-1:0] P1   = TOTAL_BITS'(PRICE1);
    localparam logic [TOTAL_BITS-1:0] P2   = TOTAL_BITS'(PRICE2);
    localparam logic [TOTAL_BITS-1:0] P3   = TOTAL_BITS'(PRICE3);
    localparam logic [TOTAL_BITS-1:0] W_LD = TOTAL_BITS'(WAIT_CYCLES);
    localparam logic [TOTAL_BITS-1:0] ZERO = '0;

    logic [1:0]            r_state;
    logic [TOTAL_BITS-1:0] r_total;
    logic [TOTAL_BITS-1:0] r_wait;
    logic [3:0]            r_avail;
    logic [3:0]            r_item;
    logic [2:0]            r_ret;
    logic                  r_rej;

    logic                  w_coin_valid;
    logic [TOTAL_BITS-1:0] w_coin_val;
    logic                  w_sel_hit;
    logic [3:0]            w_sel_item;
    logic [TOTAL_BITS-1:0] w_sel_price;
    logic [TOTAL_BITS-1:0] w_after_sel;
    logic [TOTAL_BITS:0]   w_sum;
    logic                  w_fits;
    logic [TOTAL_BITS-1:0] w_wait_dec;
    logic [2:0]            w_ret_coin;
    logic [TOTAL_BITS-1:0] w_ret_val;

    logic [1:0]            w_nxt_state;
    logic [TOTAL_BITS-1:0] w_nxt_total;
    logic [TOTAL_BITS-1:0] w_nxt_wait;
    logic [3:0]            w_nxt_item;
    logic [2:0]            w_nxt_ret;
    logic                  w_nxt_rej;
    logic [3:0]            w_nxt_avail;

    // Decode the inserted coin; anything other than exactly one bit is no coin.
    always_comb begin
        w_coin_valid = 1'b1;
        w_coin_val   = ZERO;
        case (i_input_coin)
            3'b001:  w_coin_val = C0;
            3'b010:  w_coin_val = C1;
            3'b100:  w_coin_val = C2;
            default: w_coin_valid = 1'b0;
        endcase
    end

    // Lowest-index affordable selection wins; only meaningful in CREDIT.
    always_comb begin
        w_sel_hit   = 1'b1;
        w_sel_item  = 4'b0000;
        w_sel_price = ZERO;
        if (r_state != S_CREDIT) begin
            w_sel_hit = 1'b0;
        end else if (i_select_item[0] && r_total >= P0) begin
            w_sel_item  = 4'b0001;
            w_sel_price = P0;
        end else if (i_select_item[1] && r_total >= P1) begin
            w_sel_item  = 4'b0010;
            w_sel_price = P1;
        end else if (i_select_item[2] && r_total >= P2) begin
            w_sel_item  = 4'b0100;
            w_sel_price = P2;
        end else if (i_select_item[3] && r_total >= P3) begin
            w_sel_item  = 4'b1000;
            w_sel_price = P3;
        end else begin
            w_sel_hit = 1'b0;
        end
    end

    // Largest coin that does not exceed the remaining credit.
    always_comb begin
        w_ret_coin = 3'b000;
        w_ret_val  = ZERO;
        if (r_total >= C2) begin
            w_ret_coin = 3'b100;
            w_ret_val  = C2;
        end else if (r_total >= C1) begin
            w_ret_coin = 3'b010;
            w_ret_val  = C1;
        end else if (r_total >= C0) begin
            w_ret_coin = 3'b001;
            w_ret_val  = C0;
        end
    end

    // The coin is added after the dispense; one extra bit catches overflow.
    assign w_after_sel = r_total - w_sel_price;
    assign w_sum       = {1'b0, w_after_sel} + {1'b0, w_coin_val};
    assign w_fits      = ~w_sum[TOTAL_BITS];
    assign w_wait_dec  = (r_wait == ZERO) ? ZERO : r_wait - 1'b1;

    // Next-state and next-output computation for all three states.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_total = r_total;
        w_nxt_wait  = r_wait;
        w_nxt_item  = 4'b0000;
        w_nxt_ret   = 3'b000;
        w_nxt_rej   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_coin_valid) begin
                    if (w_fits) begin
                        w_nxt_total = w_sum[TOTAL_BITS-1:0];
                        w_nxt_wait  = W_LD;
                        w_nxt_state = S_CREDIT;
                    end else begin
                        w_nxt_rej = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (i_trigger_return) begin
                    // Return wins: the coin bounces and the selection is dropped.
                    w_nxt_rej   = w_coin_valid;
                    w_nxt_wait  = w_wait_dec;
                    w_nxt_state = S_RETURN;
                end else begin
                    w_nxt_item  = w_sel_item;
                    w_nxt_total = w_after_sel;
                    if (w_coin_valid) begin
                        if (w_fits) begin
                            w_nxt_total = w_sum[TOTAL_BITS-1:0];
                        end else begin
                            w_nxt_rej = 1'b1;
                        end
                    end
                    if (w_sel_hit || (w_coin_valid && w_fits)) begin
                        w_nxt_wait = W_LD;
                    end else begin
                        w_nxt_wait = w_wait_dec;
                    end
                    if (w_nxt_total == ZERO) begin
                        w_nxt_wait  = ZERO;
                        w_nxt_state = S_IDLE;
                    end else if (!w_sel_hit && !(w_coin_valid && w_fits) &&
                                 w_wait_dec == ZERO) begin
                        w_nxt_state = S_RETURN;
                    end
                end
            end
            S_RETURN: begin
                w_nxt_rej = w_coin_valid;
                if (r_total == ZERO || w_ret_coin == 3'b000) begin
                    // A residue below the smallest coin cannot be paid; drop it.
                    w_nxt_total = ZERO;
                    w_nxt_wait  = ZERO;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_ret   = w_ret_coin;
                    w_nxt_total = r_total - w_ret_val;
                end
            end
            default: begin
                w_nxt_total = ZERO;
                w_nxt_wait  = ZERO;
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Availability is registered alongside the total it is derived from.
    always_comb begin
        w_nxt_avail = 4'b0000;
        if (w_nxt_state != S_RETURN) begin
            w_nxt_avail[0] = (w_nxt_total >= P0);
            w_nxt_avail[1] = (w_nxt_total >= P1);
            w_nxt_avail[2] = (w_nxt_total >= P2);
            w_nxt_avail[3] = (w_nxt_total >= P3);
        end
    end

    // State, credit, timer and every output are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_total <= ZERO;
            r_wait  <= ZERO;
            r_avail <= 4'b0000;
            r_item  <= 4'b0000;
            r_ret   <= 3'b000;
            r_rej   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_total <= w_nxt_total;
            r_wait  <= w_nxt_wait;
            r_avail <= w_nxt_avail;
            r_item  <= w_nxt_item;
            r_ret   <= w_nxt_ret;
            r_rej   <= w_nxt_rej;
        end
    end

    assign o_available_item = r_avail;
    assign o_output_item    = r_item;
    assign o_return_coin    = r_ret;
    assign o_coin_reject    = r_rej;
    assign current_total    = r_total;
    assign wait_time        = r_wait;
    assign o_busy           = (r_state == S_RETURN);

endmodule
